lstm_weight_fetch: RTL and testbench
====================================

Name: lstm_weight_fetch

Overview:
- Sequencer that sits directly upstream of the LSTM weight ROM.
- On each timestep it walks the Wih and then the Whh regions of the ROM and drives the ROM address.
- It captures the ROM data after a fixed read latency and streams the weights, tagged with gate and row position, to the MAC array over a valid/ready interface.
- A credit-limited output FIFO absorbs MAC backpressure, because the ROM cannot be stalled.

Parameters:
- col, 512, hidden size (rows per gate; also the Whh column count)
- cow, 96, input feature count (Wih column count)
- QZ, 16, weight width (the ROM returns two 8-bit halves packed as {hi,lo}; passed through untouched)
- RD_LAT, 1, ROM read latency in cycles (0 = combinational simulation model, 1 = registered pmi_rom)
- ADDR_W, $clog2(col*cow*4+col*col*4), ROM address width
- FIFO_D, RD_LAT+2, output FIFO depth

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins one timestep sweep
- busy  out  1  high from the start edge until done
- done  out  1  one-cycle pulse after the final beat is accepted
- rom_addr  out  ADDR_W  ROM address (registered)
- rom_data  in  QZ  ROM data, valid RD_LAT cycles after rom_addr
- w_data  out  QZ  weight beat
- w_valid  out  1  beat valid
- w_ready  in  1  consumer ready
- w_phase  out  1  0 = Wih, 1 = Whh
- w_gate  out  2  gate index 0..3 (i, f, g, o)
- w_last_k  out  1  last column of the current row/gate
- w_last_row  out  1  last row of the phase (qualified with w_last_k and gate 3)

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, all counters 0.
- Reset asserted mid-sweep aborts immediately; in-flight ROM reads are discarded.

ROM memory map:
- Wih region: addr = g*col*cow + r*cow + k.
- Whh region: addr = col*cow*4 + g*col*col + r*col + k.
- Issue order is nested: r outer, then g, then k inner.
- Counters: k wraps at cow in Wih and at col in Whh; g wraps at 4; r wraps at col, which ends the phase.

FSM:
- IDLE: waits for start; start is ignored while busy.
- WIH: issues Wih addresses; after the last one is issued, goes to WHH.
- WHH: issues Whh addresses; after the last one is issued, goes to DRAIN.
- DRAIN: waits until inflight = 0 and the FIFO is empty, then goes to IDLE and pulses done.

Issue and credit rules:
- An address issues in a cycle only when (fifo_count + inflight − pop) < FIFO_D, where pop = w_valid & w_ready.
- This sustains 1 beat/cycle while w_ready stays high.
- An RD_LAT-deep valid shift register tags each issued address. Its payload (phase, gate, last_k, last_row) travels alongside, and rom_data is pushed into the FIFO when the tag emerges.
- The FIFO never overflows; overflow is an assertion failure.

Latency and ordering:
- With w_ready high, first w_valid rises RD_LAT+2 cycles after start is sampled.
- A full sweep with no stalls takes 4*col*(cow+col) + RD_LAT + 2 cycles from start to done.
- w_data/tags hold stable while w_valid & !w_ready.
- Beats are emitted strictly in issue order; none are dropped or duplicated.
- w_ready low for N cycles stalls issue after at most FIFO_D − inflight further addresses.

Decomposition:
- Package lstm_wfetch_pkg: phase_e {PH_WIH, PH_WHH}, gate_e {G_I, G_F, G_G, G_O}, fsm_e {IDLE, WIH, WHH, DRAIN}, beat_tag_t struct {phase, gate, last_k, last_row}.
- The package also holds localparams WIH_SIZE = col*cow*4 and WHH_BASE = WIH_SIZE.
- Sub-module lstm_wfetch_fifo: synchronous FIFO (depth FIFO_D, width QZ+$bits(beat_tag_t)) with registered count output, shared clk/rst_n.

Test Plan (col=4, cow=3, RD_LAT=1 unless noted; ROM model returns data = address):
- Basic sweep: start, w_ready=1 → 112 beats; beat0 w_data=0; beat3 (r0 g1 k0) = 12; beat12 (r1 g0 k0) = 3; beat48 (Whh r0 g0 k0) = 48, w_phase=1; beat52 (r0 g1 k0) = 64; done pulses after beat111; total 115 cycles.
- Tag check: w_last_k high on every 3rd Wih beat and every 4th Whh beat; w_last_row high only on beats 47 and 111.
- Backpressure: random w_ready with 30% low → identical 112-beat sequence; data/tags stable while stalled; FIFO count never exceeds 3.
- Latency sweep: repeat the basic sweep with RD_LAT=0 and RD_LAT=3 → same beat sequence; first w_valid at 2 and 5 cycles after start respectively.
- Start while busy: pulse start at beat 20 → ignored; exactly 112 beats, one done pulse.
- Reset mid-sweep: rst_n low at beat 60 → w_valid, busy, done, rom_addr all 0 immediately; a new start yields a fresh sweep beginning at address 0.

Source files
------------

// File: rtl/lstm_wfetch_pkg.sv
// lstm_wfetch_pkg: shared types and memory-map constants for the LSTM weight fetcher.
package lstm_wfetch_pkg;
    typedef enum logic {PH_WIH, PH_WHH} phase_e;
    typedef enum logic [1:0] {G_I, G_F, G_G, G_O} gate_e;
    typedef enum logic [1:0] {IDLE, WIH, WHH, DRAIN} fsm_e;

    typedef struct packed {
        phase_e phase;
        gate_e  gate;
        logic   last_k;
        logic   last_row;
    } beat_tag_t;

    localparam int COL_DEF  = 512;
    localparam int COW_DEF  = 96;
    localparam int WIH_SIZE = COL_DEF * COW_DEF * 4;
    localparam int WHH_BASE = WIH_SIZE;

    function automatic int wih_size(input int n_col, input int n_cow);
        return n_col * n_cow * 4;
    endfunction
endpackage

// File: rtl/lstm_wfetch_fifo.sv
// lstm_wfetch_fifo: show-ahead synchronous FIFO holding tagged weight beats, with a registered count.
module lstm_wfetch_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 21,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop   = i_pop && r_count != '0;
    assign o_data  = r_mem[r_rp];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp == PW'(DEPTH - 1) ? '0 : r_wp + PW'(1);
            end
            if (w_pop) r_rp <= r_rp == PW'(DEPTH - 1) ? '0 : r_rp + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    // The ROM cannot be stalled, so a push into a full FIFO would lose a weight.
    assert property (@(posedge clk) disable iff (!rst_n) !(i_push && !w_pop && r_count == CW'(DEPTH)));
endmodule

// File: rtl/lstm_weight_fetch.sv
// lstm_weight_fetch: walks the Wih then Whh ROM regions once per timestep and streams tagged
// weights to the MAC array, using credits so the unstallable ROM never overruns the output FIFO.
module lstm_weight_fetch
    import lstm_wfetch_pkg::*;
#(
    parameter int col    = COL_DEF,
    parameter int cow    = COW_DEF,
    parameter int QZ     = 16,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = $clog2(col * cow * 4 + col * col * 4),
    parameter int FIFO_D = RD_LAT + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [QZ-1:0]     rom_data,
    output logic [QZ-1:0]     w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_phase,
    output logic [1:0]        w_gate,
    output logic              w_last_k,
    output logic              w_last_row
);
    localparam int TW    = $bits(beat_tag_t);
    localparam int CW    = $clog2(FIFO_D + 1);
    localparam int NS    = RD_LAT + 1;
    localparam int KW    = $clog2((col > cow ? col : cow) + 1);
    localparam int RW    = $clog2(col + 1);
    localparam int WHH_B = wih_size(col, cow);

    fsm_e              r_state;
    logic              r_busy, r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [KW-1:0]     r_k;
    logic [1:0]        r_g;
    logic [RW-1:0]     r_r;
    logic [NS-1:0]     r_sv;
    beat_tag_t         r_st [NS];
    logic              w_phase_cur, w_k_end, w_g_end, w_r_end, w_row_end, w_issue, w_pop;
    logic [ADDR_W-1:0] w_addr;
    logic [CW-1:0]     w_count, w_inflight;
    beat_tag_t         w_tag, w_otag;
    logic [QZ+TW-1:0]  w_fifo_q;

    assign w_phase_cur = r_state == WHH;
    assign w_k_end     = r_k == (w_phase_cur ? KW'(col - 1) : KW'(cow - 1));
    assign w_g_end     = r_g == 2'd3;
    assign w_r_end     = r_r == RW'(col - 1);
    assign w_row_end   = w_k_end && w_g_end && w_r_end;
    assign w_addr      = (w_phase_cur ? ADDR_W'(WHH_B) : ADDR_W'(0))
                       + ADDR_W'(r_g) * (w_phase_cur ? ADDR_W'(col * col) : ADDR_W'(col * cow))
                       + ADDR_W'(r_r) * (w_phase_cur ? ADDR_W'(col) : ADDR_W'(cow))
                       + ADDR_W'(r_k);
    assign w_tag       = '{phase: phase_e'(w_phase_cur), gate: gate_e'(r_g), last_k: w_k_end, last_row: w_row_end};
    assign w_pop       = w_valid && w_ready;
    // A credit covers beats already queued plus reads still travelling through the ROM.
    assign w_issue     = (r_state == WIH || r_state == WHH)
                       && (int'(w_count) + int'(w_inflight) - int'(w_pop) < FIFO_D);

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < NS; i++) w_inflight = w_inflight + CW'(r_sv[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_k     <= '0;
            r_g     <= '0;
            r_r     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_issue) r_addr <= w_addr;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= WIH;
                    r_busy  <= 1'b1;
                end
                WIH, WHH: if (w_issue) begin
                    r_k <= w_k_end ? '0 : r_k + KW'(1);
                    if (w_k_end) r_g <= r_g + 2'd1;
                    if (w_k_end && w_g_end) r_r <= w_r_end ? '0 : r_r + RW'(1);
                    if (w_row_end) r_state <= (r_state == WIH) ? WHH : DRAIN;
                end
                DRAIN: if (w_inflight == '0 && w_count == CW'(w_pop)) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stage 0 travels with rom_addr; the last stage lines up with rom_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sv <= '0;
            for (int i = 0; i < NS; i++) r_st[i] <= '0;
        end else begin
            r_sv[0] <= w_issue;
            r_st[0] <= w_tag;
            for (int i = 1; i < NS; i++) begin
                r_sv[i] <= r_sv[i-1];
                r_st[i] <= r_st[i-1];
            end
        end
    end

    lstm_wfetch_fifo #(.DEPTH(FIFO_D), .WIDTH(QZ + TW), .CW(CW)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_sv[NS-1]),
        .i_pop  (w_pop),
        .i_data ({rom_data, r_st[NS-1]}),
        .o_data (w_fifo_q),
        .o_count(w_count)
    );

    assign {w_data, w_otag} = w_fifo_q;
    assign busy       = r_busy;
    assign done       = r_done;
    assign rom_addr   = r_addr;
    assign w_valid    = w_count != '0;
    assign w_phase    = w_otag.phase;
    assign w_gate     = w_otag.gate;
    assign w_last_k   = w_otag.last_k;
    assign w_last_row = w_otag.last_row;
endmodule

// File: tb/tb_lstm_weight_fetch.sv
// tb_lstm_weight_fetch: directed checks of the weight fetcher at col=4, cow=3 with ROM latencies 0, 1 and 3.
module tb_lstm_weight_fetch;
    localparam int COL = 4;
    localparam int COW = 3;
    localparam int QZ  = 16;
    localparam int AW  = 7;
    localparam int NB  = 4 * COL * (COW + COL);

    typedef logic [QZ+4:0] beat_t;
    typedef struct { int idx; beat_t want; } vec_t;

    logic clk = 1'b0;
    logic rst_n, start;
    logic [2:0] rdy, busy, done, vld, ph, lk, lr;
    logic [2:0][1:0]    gt;
    logic [2:0][QZ-1:0] wd, rd;
    logic [2:0][AW-1:0] ra;

    beat_t cap [3][NB+8];
    int    nb [3], first [3], nd [3], tdone [3];
    int    nvec = 0, nbad = 0;
    vec_t  tbl [12];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int L = (i == 2) ? 3 : i;
        logic [QZ-1:0] pipe [3];
        always @(posedge clk) begin
            pipe[0] <= QZ'(ra[i]);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign rd[i] = (L == 0) ? QZ'(ra[i]) : pipe[(L == 0) ? 0 : L - 1];
        lstm_weight_fetch #(.col(COL), .cow(COW), .QZ(QZ), .RD_LAT(L)) u (
            .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[i]), .done(done[i]),
            .rom_addr(ra[i]), .rom_data(rd[i]), .w_data(wd[i]), .w_valid(vld[i]),
            .w_ready(rdy[i]), .w_phase(ph[i]), .w_gate(gt[i]), .w_last_k(lk[i]),
            .w_last_row(lr[i])
        );
    end

    function automatic beat_t mk(int d, bit p, int gi, bit k, bit r);
        return {QZ'(d), p, 2'(gi), k, r};
    endfunction

    function automatic beat_t exp_beat(int n);
        int r, gi, k, a, kn;
        bit p;
        p  = n >= 4 * COL * COW;
        kn = p ? COL : COW;
        if (p) n = n - 4 * COL * COW;
        r  = n / (4 * kn);
        gi = (n / kn) % 4;
        k  = n % kn;
        a  = p ? 4 * COL * COW + gi * COL * COL + r * COL + k : gi * COL * COW + r * COW + k;
        return mk(a, p, gi, k == kn - 1, k == kn - 1 && gi == 3 && r == COL - 1);
    endfunction

    function automatic beat_t pk(int j);
        return {wd[j], ph[j], gt[j], lk[j], lr[j]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic chk_stream(input int j, input string nm);
        chk({nm, "_count"}, nb[j], NB);
        for (int n = 0; n < NB && n < nb[j]; n++)
            chk($sformatf("%s_beat%0d", nm, n), 32'(cap[j][n]), 32'(exp_beat(n)));
    endtask

    task automatic sweep(input bit bp, input int restart_at, input int stop_at);
        bit    hold = 1'b0, restarted = 1'b0, pulse = 1'b0;
        beat_t hv = '0;
        int    cyc = 0;
        for (int j = 0; j < 3; j++) begin
            nb[j] = 0; first[j] = -1; nd[j] = 0; tdone[j] = -1;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        rdy[1] = bp ? ($urandom_range(0, 9) > 2) : 1'b1;
        while (cyc < 2000) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (vld[j] && first[j] < 0) first[j] = cyc;
                if (vld[j] && rdy[j] && nb[j] < NB + 8) begin
                    cap[j][nb[j]] = pk(j);
                    nb[j]++;
                end
                if (done[j]) begin
                    nd[j]++;
                    tdone[j] = cyc;
                end
            end
            if (hold) chk("stall_hold", 32'({vld[1], pk(1)}), 32'({1'b1, hv}));
            hold = vld[1] && !rdy[1];
            hv   = pk(1);
            if (stop_at >= 0 && nb[1] == stop_at) return;
            if (nd[1] > 0 && nd[2] > 0) break;
            pulse = restart_at >= 0 && nb[1] == restart_at && !restarted;
            if (pulse) restarted = 1'b1;
            @(posedge clk);
            cyc++;
            #1 start = pulse;
            rdy[1] = bp ? ($urandom_range(0, 9) > 2) : 1'b1;
        end
    endtask

    initial begin
        tbl[0]  = '{0,   mk(0,   0, 0, 0, 0)};
        tbl[1]  = '{2,   mk(2,   0, 0, 1, 0)};
        tbl[2]  = '{3,   mk(12,  0, 1, 0, 0)};
        tbl[3]  = '{11,  mk(38,  0, 3, 1, 0)};
        tbl[4]  = '{12,  mk(3,   0, 0, 0, 0)};
        tbl[5]  = '{47,  mk(47,  0, 3, 1, 1)};
        tbl[6]  = '{48,  mk(48,  1, 0, 0, 0)};
        tbl[7]  = '{51,  mk(51,  1, 0, 1, 0)};
        tbl[8]  = '{52,  mk(64,  1, 1, 0, 0)};
        tbl[9]  = '{63,  mk(99,  1, 3, 1, 0)};
        tbl[10] = '{64,  mk(52,  1, 0, 0, 0)};
        tbl[11] = '{111, mk(111, 1, 3, 1, 1)};

        rst_n = 1'b0;
        start = 1'b0;
        rdy   = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy[1], 0);
        chk("reset_done", done[1], 0);
        chk("reset_valid", vld[1], 0);
        chk("reset_addr", ra[1], 0);
        #1 rst_n = 1'b1;

        sweep(1'b0, -1, -1);
        chk_stream(1, "basic");
        for (int i = 0; i < 12; i++)
            chk($sformatf("tbl_beat%0d", tbl[i].idx), 32'(cap[1][tbl[i].idx]), 32'(tbl[i].want));
        chk("basic_first_valid", first[1], 3);
        chk("basic_done_cycle", tdone[1], 115);
        chk("basic_done_pulses", nd[1], 1);
        chk_stream(0, "lat0");
        chk("lat0_first_valid", first[0], 2);
        chk("lat0_done_cycle", tdone[0], 114);
        chk_stream(2, "lat3");
        chk("lat3_first_valid", first[2], 5);
        chk("lat3_done_cycle", tdone[2], 117);

        sweep(1'b1, -1, -1);
        chk_stream(1, "bp");
        chk("bp_done_pulses", nd[1], 1);

        sweep(1'b0, 20, -1);
        chk_stream(1, "restart");
        chk("restart_done_pulses", nd[1], 1);
        chk("restart_done_cycle", tdone[1], 115);
        repeat (5) @(negedge clk);
        chk("restart_idle_busy", busy[1], 0);
        chk("restart_idle_valid", vld[1], 0);

        sweep(1'b0, -1, 60);
        chk("pre_reset_busy", busy[1], 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", vld[1], 0);
        chk("midreset_busy", busy[1], 0);
        chk("midreset_done", done[1], 0);
        chk("midreset_addr", ra[1], 0);
        @(posedge clk); #1 rst_n = 1'b1;
        sweep(1'b0, -1, -1);
        chk_stream(1, "after_reset");
        chk("after_reset_first_valid", first[1], 3);
        chk("after_reset_done_cycle", tdone[1], 115);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
